// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/redirect sequencer.
// Holds the FSM state encoding and the operand-match rule used by the hazard compare.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int         REG_W  = 5;

    // x0 is hardwired to zero, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic             use_rs,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rd,
                                       input logic             regwrite);
        return use_rs && (rs != REG_X0) && (rs == rd) && regwrite;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline registers (master) and the hazard sequencer (slave).
// Pure wiring: no storage, no latency, no backpressure.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
    import hazard_pkg::*;

    logic [REG_W-1:0] id_rs1_i;
    logic [REG_W-1:0] id_rs2_i;
    logic             id_use_rs1_i;
    logic             id_use_rs2_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             ex_regwrite_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] mem_rd_i;
    logic             mem_regwrite_i;
    logic [REG_W-1:0] wb_rd_i;
    logic             wb_regwrite_i;
    logic             mem_redirect_i;

    logic             pc_we_o;
    logic             ifid_we_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             wdog_err_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_regwrite_i, ex_memread_i,
               mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i, mem_redirect_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
               stall_cnt_o, flush_cnt_o, wdog_err_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_regwrite_i, ex_memread_i,
               mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i, mem_redirect_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
               stall_cnt_o, flush_cnt_o, wdog_err_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clr wins over inc.
// One-cycle update latency, no backpressure (holds at all-ones).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-hazard stall and MEM-stage redirect sequencer driving pipeline-register enables/flushes.
// Enables and flushes are combinational (zero latency); counters and watchdog update on the edge.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FORWARDING    = 0,
    parameter int CNT_W         = 32,
    parameter int STALL_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [RUN_W:0] TIMEOUT_V = (RUN_W + 1)'(STALL_TIMEOUT);

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic             hazard;
    logic             redir_ok;
    logic             illegal;
    logic             take_redir;
    logic             take_stall;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W:0]   run_next;
    logic             wdog_q;

    always_comb begin
        hazard = 1'b0;
        if (FORWARDING != 0) begin
            // Only a load in EX cannot be forwarded in time.
            hazard = bus.ex_memread_i &&
                     (reg_match(bus.id_use_rs1_i, bus.id_rs1_i, bus.ex_rd_i, bus.ex_regwrite_i) ||
                      reg_match(bus.id_use_rs2_i, bus.id_rs2_i, bus.ex_rd_i, bus.ex_regwrite_i));
        end else begin
            hazard = reg_match(bus.id_use_rs1_i, bus.id_rs1_i, bus.ex_rd_i,  bus.ex_regwrite_i)  ||
                     reg_match(bus.id_use_rs2_i, bus.id_rs2_i, bus.ex_rd_i,  bus.ex_regwrite_i)  ||
                     reg_match(bus.id_use_rs1_i, bus.id_rs1_i, bus.mem_rd_i, bus.mem_regwrite_i) ||
                     reg_match(bus.id_use_rs2_i, bus.id_rs2_i, bus.mem_rd_i, bus.mem_regwrite_i) ||
                     reg_match(bus.id_use_rs1_i, bus.id_rs1_i, bus.wb_rd_i,  bus.wb_regwrite_i)  ||
                     reg_match(bus.id_use_rs2_i, bus.id_rs2_i, bus.wb_rd_i,  bus.wb_regwrite_i);
        end
    end

    always_comb begin
        state_d           = RUN;
        redir_ok          = 1'b0;
        illegal           = 1'b0;
        take_redir        = 1'b0;
        take_stall        = 1'b0;
        bus.pc_we_o       = 1'b1;
        bus.ifid_we_o     = 1'b1;
        bus.ifid_flush_o  = 1'b0;
        bus.idex_flush_o  = 1'b0;
        bus.exmem_flush_o = 1'b0;

        // The cycle after a redirect EX/MEM holds a bubble, so its redirect bit is stale.
        case (state_q)
            RUN, STALL: redir_ok = 1'b1;
            FLUSH:      redir_ok = 1'b0;
            default:    illegal  = 1'b1;
        endcase

        if (rst) begin
            bus.pc_we_o       = 1'b0;
            bus.ifid_we_o     = 1'b0;
            bus.ifid_flush_o  = 1'b1;
            bus.idex_flush_o  = 1'b1;
            bus.exmem_flush_o = 1'b1;
        end else if (redir_ok && bus.mem_redirect_i) begin
            bus.ifid_flush_o  = 1'b1;
            bus.idex_flush_o  = 1'b1;
            bus.exmem_flush_o = 1'b1;
            take_redir        = 1'b1;
            state_d           = FLUSH;
        end else if (hazard) begin
            bus.pc_we_o       = 1'b0;
            bus.ifid_we_o     = 1'b0;
            bus.idex_flush_o  = 1'b1;
            take_stall        = 1'b1;
            state_d           = STALL;
        end

        if (illegal) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk), .rst (rst), .inc (take_stall), .clr (1'b0), .cnt (bus.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk), .rst (rst), .inc (take_redir), .clr (1'b0), .cnt (bus.flush_cnt_o)
    );

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk (clk), .rst (rst), .inc (take_stall), .clr (!take_stall), .cnt (run_cnt)
    );

    assign run_next = {1'b0, run_cnt} + {{RUN_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= 1'b0;
        end else if (take_stall && (run_next >= TIMEOUT_V)) begin
            wdog_q <= 1'b1;
        end
    end

    assign bus.wdog_err_o = wdog_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: forwarding and non-forwarding instances plus a narrow-counter instance.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 15;
    localparam int SAT = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1, rs2, exrd, memrd, wbrd;
    logic       use1, use2, exrw, exmr, memrw, wbrw, redir;

    int n_cmp = 0;
    int n_bad = 0;

    int m_stall[2], m_flush[2], m_run[2];
    bit m_wdog[2], m_inflush[2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) bus1 ();
    pipeline_hazard_ctrl_if #(.CNT_W(32)) bus0 ();
    pipeline_hazard_ctrl_if #(.CNT_W(3))  buss ();

    assign {bus1.id_rs1_i, bus1.id_rs2_i, bus1.id_use_rs1_i, bus1.id_use_rs2_i, bus1.ex_rd_i, bus1.ex_regwrite_i,
            bus1.ex_memread_i, bus1.mem_rd_i, bus1.mem_regwrite_i, bus1.wb_rd_i, bus1.wb_regwrite_i, bus1.mem_redirect_i}
         = {rs1, rs2, use1, use2, exrd, exrw, exmr, memrd, memrw, wbrd, wbrw, redir};
    assign {bus0.id_rs1_i, bus0.id_rs2_i, bus0.id_use_rs1_i, bus0.id_use_rs2_i, bus0.ex_rd_i, bus0.ex_regwrite_i,
            bus0.ex_memread_i, bus0.mem_rd_i, bus0.mem_regwrite_i, bus0.wb_rd_i, bus0.wb_regwrite_i, bus0.mem_redirect_i}
         = {rs1, rs2, use1, use2, exrd, exrw, exmr, memrd, memrw, wbrd, wbrw, redir};
    assign {buss.id_rs1_i, buss.id_rs2_i, buss.id_use_rs1_i, buss.id_use_rs2_i, buss.ex_rd_i, buss.ex_regwrite_i,
            buss.ex_memread_i, buss.mem_rd_i, buss.mem_regwrite_i, buss.wb_rd_i, buss.wb_regwrite_i, buss.mem_redirect_i}
         = {rs1, rs2, use1, use2, exrd, exrw, exmr, memrd, memrw, wbrd, wbrw, redir};

    pipeline_hazard_ctrl #(.FORWARDING(1), .CNT_W(32), .STALL_TIMEOUT(TMO)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipeline_hazard_ctrl #(.FORWARDING(0), .CNT_W(32), .STALL_TIMEOUT(TMO)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipeline_hazard_ctrl #(.FORWARDING(0), .CNT_W(3),  .STALL_TIMEOUT(TMO)) duts (.clk(clk), .rst(rst), .bus(buss));

    typedef struct {
        logic [4:0] rs1, rs2, exrd, memrd, wbrd;
        bit         use1, use2, exrw, exmr, memrw, wbrw;
        bit         st1, st0;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit mt(bit u, logic [4:0] rs, logic [4:0] rd, bit rw);
        return u && (rs != 5'd0) && (rs == rd) && rw;
    endfunction

    function automatic bit hz(int fwd);
        bit ex_m;
        ex_m = mt(use1, rs1, exrd, exrw) || mt(use2, rs2, exrd, exrw);
        if (fwd != 0) return exmr && ex_m;
        return ex_m || mt(use1, rs1, memrd, memrw) || mt(use2, rs2, memrd, memrw)
                    || mt(use1, rs1, wbrd, wbrw)   || mt(use2, rs2, wbrd, wbrw);
    endfunction

    // Expected {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush} for mode m.
    function automatic logic [4:0] exp_ctl(int m);
        if (rst) return 5'b00111;
        if (redir && !m_inflush[m]) return 5'b11111;
        if (hz(m)) return 5'b00010;
        return 5'b11000;
    endfunction

    task automatic check_comb();
        chk("ctl_fwd1", {bus1.pc_we_o, bus1.ifid_we_o, bus1.ifid_flush_o, bus1.idex_flush_o, bus1.exmem_flush_o}, exp_ctl(1));
        chk("ctl_fwd0", {bus0.pc_we_o, bus0.ifid_we_o, bus0.ifid_flush_o, bus0.idex_flush_o, bus0.exmem_flush_o}, exp_ctl(0));
        chk("ctl_sat",  {buss.pc_we_o, buss.ifid_we_o, buss.ifid_flush_o, buss.idex_flush_o, buss.exmem_flush_o}, exp_ctl(0));
    endtask

    task automatic update_model();
        for (int m = 0; m < 2; m++) begin
            bit take, stall;
            if (rst) begin
                m_stall[m] = 0; m_flush[m] = 0; m_run[m] = 0; m_wdog[m] = 0; m_inflush[m] = 0;
            end else begin
                take  = redir && !m_inflush[m];
                stall = !take && hz(m);
                if (stall) m_stall[m]++;
                if (take)  m_flush[m]++;
                m_run[m] = stall ? ((m_run[m] < TMO) ? m_run[m] + 1 : TMO) : 0;
                if (m_run[m] == TMO) m_wdog[m] = 1;
                m_inflush[m] = take;
            end
        end
    endtask

    task automatic check_regs();
        chk("stall_cnt_fwd1", bus1.stall_cnt_o, m_stall[1]);
        chk("flush_cnt_fwd1", bus1.flush_cnt_o, m_flush[1]);
        chk("wdog_fwd1",      bus1.wdog_err_o,  m_wdog[1]);
        chk("stall_cnt_fwd0", bus0.stall_cnt_o, m_stall[0]);
        chk("flush_cnt_fwd0", bus0.flush_cnt_o, m_flush[0]);
        chk("wdog_fwd0",      bus0.wdog_err_o,  m_wdog[0]);
        chk("stall_cnt_sat",  buss.stall_cnt_o, (m_stall[0] > SAT) ? SAT : m_stall[0]);
        chk("flush_cnt_sat",  buss.flush_cnt_o, (m_flush[0] > SAT) ? SAT : m_flush[0]);
    endtask

    task automatic tick();
        @(negedge clk);
        check_comb();
        update_model();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic clr_in();
        {rs1, rs2, exrd, memrd, wbrd} = '0;
        {use1, use2, exrw, exmr, memrw, wbrw, redir} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] r);
        clr_in();
        rs1 = r; use1 = 1; exrd = r; exrw = 1; exmr = 1;
    endtask

    initial begin
        //        rs1    rs2    exrd   memrd  wbrd   u1 u2 exw exm mw wbw st1 st0
        vt[0] = '{5'd5,  5'd0,  5'd5,  5'd0,  5'd0,  1, 0, 1,  1,  0, 0,  1,  1};
        vt[1] = '{5'd5,  5'd0,  5'd5,  5'd0,  5'd0,  1, 0, 1,  0,  0, 0,  0,  1};
        vt[2] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1, 0, 1,  1,  0, 0,  0,  0};
        vt[3] = '{5'd5,  5'd0,  5'd5,  5'd0,  5'd0,  0, 0, 1,  1,  0, 0,  0,  0};
        vt[4] = '{5'd5,  5'd0,  5'd5,  5'd0,  5'd0,  1, 0, 0,  1,  0, 0,  0,  0};
        vt[5] = '{5'd0,  5'd7,  5'd0,  5'd7,  5'd0,  0, 1, 0,  0,  1, 0,  0,  1};
        vt[6] = '{5'd9,  5'd0,  5'd0,  5'd0,  5'd9,  1, 0, 0,  0,  0, 1,  0,  1};
        vt[7] = '{5'd3,  5'd0,  5'd4,  5'd5,  5'd6,  1, 1, 1,  1,  1, 1,  0,  0};
        vt[8] = '{5'd0,  5'd31, 5'd31, 5'd0,  5'd0,  0, 1, 1,  1,  0, 0,  1,  1};

        clr_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            {rs1, rs2, exrd, memrd, wbrd} = {vt[i].rs1, vt[i].rs2, vt[i].exrd, vt[i].memrd, vt[i].wbrd};
            {use1, use2, exrw, exmr, memrw, wbrw} = {vt[i].use1, vt[i].use2, vt[i].exrw, vt[i].exmr, vt[i].memrw, vt[i].wbrw};
            redir = 0;
            #1;
            chk($sformatf("vec%0d_pc_we_fwd1", i), bus1.pc_we_o, !vt[i].st1);
            chk($sformatf("vec%0d_pc_we_fwd0", i), bus0.pc_we_o, !vt[i].st0);
            chk($sformatf("vec%0d_idex_fl_fwd0", i), bus0.idex_flush_o, vt[i].st0);
            tick();
            clr_in();
            do_reset();
        end

        // Load-use with forwarding: single bubble, then the load moves to MEM.
        load_use(5'd5);
        #1 chk("lu_pc_we", bus1.pc_we_o, 0);
        tick();
        exrw = 0; exmr = 0; exrd = 0; memrd = 5; memrw = 1;
        #1 chk("lu_resume", bus1.pc_we_o, 1);
        tick();
        chk("lu_stall_cnt", bus1.stall_cnt_o, 1);
        clr_in();
        do_reset();

        // No forwarding: dependent add waits through EX, MEM and WB.
        rs1 = 3; use1 = 1; exrd = 3; exrw = 1;
        tick();
        exrd = 0; exrw = 0; memrd = 3; memrw = 1;
        tick();
        memrd = 0; memrw = 0; wbrd = 3; wbrw = 1;
        tick();
        wbrd = 0; wbrw = 0;
        #1 chk("raw_resume", bus0.pc_we_o, 1);
        tick();
        chk("raw_stall_cnt_fwd0", bus0.stall_cnt_o, 3);
        chk("raw_stall_cnt_fwd1", bus1.stall_cnt_o, 0);
        clr_in();
        do_reset();

        // Redirect together with a load-use hazard, then a stale redirect in FLUSH.
        load_use(5'd6);
        redir = 1;
        #1 chk("rd_ctl", {bus1.pc_we_o, bus1.ifid_flush_o, bus1.idex_flush_o, bus1.exmem_flush_o}, 4'b1111);
        tick();
        chk("rd_flush_cnt", bus1.flush_cnt_o, 1);
        chk("rd_stall_cnt", bus1.stall_cnt_o, 0);
        clr_in();
        redir = 1;
        #1 chk("rd_ignored_in_flush", bus1.exmem_flush_o, 0);
        tick();
        chk("rd_flush_cnt_hold", bus1.flush_cnt_o, 1);
        clr_in();
        do_reset();

        // Watchdog and counter saturation on a long stall.
        load_use(5'd8);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("wdog_before", bus1.wdog_err_o, 0);
        tick();
        chk("wdog_at_timeout", bus1.wdog_err_o, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_stall_cap", buss.stall_cnt_o, SAT);
        clr_in();
        tick();
        tick();
        chk("wdog_sticky", bus1.wdog_err_o, 1);
        do_reset();
        chk("wdog_cleared", bus1.wdog_err_o, 0);

        // Reset asserted mid-stall.
        load_use(5'd4);
        tick();
        tick();
        rst = 1;
        #1 chk("rst_ctl", {bus1.pc_we_o, bus1.ifid_we_o, bus1.ifid_flush_o, bus1.idex_flush_o, bus1.exmem_flush_o}, 5'b00111);
        tick();
        chk("rst_stall_cnt", bus1.stall_cnt_o, 0);
        rst = 0;
        clr_in();
        #1 chk("rst_run", bus1.pc_we_o, 1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            exrd  = 5'($urandom_range(0, 3));
            memrd = 5'($urandom_range(0, 3));
            wbrd  = 5'($urandom_range(0, 3));
            use1  = 1'($urandom_range(0, 1));
            use2  = 1'($urandom_range(0, 1));
            exrw  = 1'($urandom_range(0, 1));
            exmr  = 1'($urandom_range(0, 1));
            memrw = 1'($urandom_range(0, 1));
            wbrw  = 1'($urandom_range(0, 1));
            redir = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
